spectro_frame_pingpong: RTL and testbench
=========================================

Name: spectro_frame_pingpong

Overview:
- Parametrised two-bank (ping-pong) frame buffer for spectrogram columns, single clock.
- The writer streams one frame of FRAME_LEN bins into the free bank. Address generation is internal; the writer supplies no addresses.
- The reader drains completed frames in write order through a registered valid/ready output stream.
- Sits between the quantiser output and the column serialiser. Replaces the dual-clock, externally addressed two-bank memory.

Parameters:
- DATA_W, 3, bits per stored bin.
- FRAME_LEN, 200, bins per frame (per bank). Legal range 2..1024.
- ADDR_W, $clog2(FRAME_LEN), localparam. Bin index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  writer offers wr_data.
- wr_ready  out  1  buffer accepts wr_data this cycle.
- wr_data  in  DATA_W  bin value.
- frame_done  out  1  one-cycle pulse: the last bin of a frame was accepted.
- rd_valid  out  1  rd_data/rd_index/rd_last valid.
- rd_ready  in  1  reader accepts.
- rd_data  out  DATA_W  bin value.
- rd_index  out  ADDR_W  bin position within the frame, 0..FRAME_LEN-1.
- rd_last  out  1  high with the final bin of a frame.
- frames_ready  out  2  number of banks holding a complete, not-yet-fetched frame (0..2).

Behaviour:
- **Storage:** two arrays mem[0], mem[1], each FRAME_LEN x DATA_W. Contents are not reset.
- **State registers:** wb (write bank), wcnt (write index), full[1:0], rb (read bank), rcnt (read fetch index).
- **Reset:** wb=0, rb=0, wcnt=0, rcnt=0, full=00.
  - All outputs reset low or zero: wr_ready=1 after reset, rd_valid=0, rd_data=0, rd_index=0, rd_last=0, frame_done=0, frames_ready=0.
  - Reset asserted mid-frame discards all partial and complete frames.
- **Write side:**
  - wr_ready = ~full[wb] (combinational from registers).
  - On wr_valid & wr_ready: mem[wb][wcnt] <= wr_data, then wcnt++.
  - When wcnt == FRAME_LEN-1 is accepted: wcnt <= 0, full[wb] <= 1, wb <= ~wb, frame_done pulses next cycle.
- **Read side:**
  - The output register loads when full[rb] & (~rd_valid | rd_ready).
  - Load action: rd_data <= mem[rb][rcnt], rd_index <= rcnt, rd_last <= (rcnt == FRAME_LEN-1), rd_valid <= 1, rcnt++.
  - Load latency: the first bin appears 1 cycle after full[rb] rises.
  - Throughput: 1 bin/cycle while rd_ready=1.
- **Bank release:**
  - Fetching rcnt == FRAME_LEN-1 clears full[rb], sets rb <= ~rb, rcnt <= 0.
  - The bank is reusable by the writer the cycle after this fetch; the last bin remains held in the output register.
- **Output hold:** if rd_valid & ~rd_ready and no load occurs, rd_valid and all rd_* hold stable (AXI-style). rd_valid drops only after acceptance with no new load.
- **Simultaneous events:**
  - Write completion and read release in the same cycle always target different banks. Both take effect.
  - wb == rb with full[wb]=1 means the writer is stalled, so no conflict arises.
- **frames_ready:** full[0] + full[1], registered view.
- **Ordering:** frames exit in write order; no frame is ever overwritten while full.

Optional Feature:
- Macro: SPECTRO_FRAME_DROP_EN.
- **Defined:**
  - wr_ready is tied to 1.
  - A frame that starts when full[wb]=1 is discarded: bins are counted but not stored, full and wb are unchanged, frame_done does not pulse.
  - Added port drop_count out 8: increments at the end of each discarded frame, saturates at 255, resets to 0.
- **Undefined:** backpressure behaviour as above; no drop_count port.

Test Plan:
- **Reset values:** reset 2 cycles -> wr_ready=1, rd_valid=0, frames_ready=0, frame_done=0.
- **Single frame:** FRAME_LEN=4, write 1,2,3,4 back-to-back, rd_ready=1 -> frame_done pulses after the 4th accept. rd_data 1,2,3,4 on consecutive cycles starting 1 cycle after full. rd_index 0..3, rd_last only on 4.
- **Writer stall:** FRAME_LEN=4, rd_ready=0, write 3 frames -> after 8 accepts frames_ready=2 and wr_ready=0. Raise rd_ready: frame 1 read out, wr_ready=1 the cycle after its last fetch, frame 3 accepted, frames read in order 1,2,3.
- **Output hold:** toggle rd_ready 0/1 every cycle mid-frame -> rd_data stable while rd_valid & ~rd_ready; no bin lost or duplicated; rd_index strictly sequential.
- **Mid-frame reset:** reset after 2 of 4 bins written with one frame full -> frames_ready=0, rd_valid=0. The next full frame reads back from bank 0 with index 0.
- **Drop mode (SPECTRO_FRAME_DROP_EN):** rd_ready=0, write 3 frames -> frames 1 and 2 retained, drop_count=1, wr_ready stays 1. Draining returns frames 1, 2 only.

Source files
------------

// File: rtl/spectro_frame_pingpong.sv
// rtl/spectro_frame_pingpong.sv - two-bank ping-pong frame buffer for spectrogram columns
// Optional macro SPECTRO_FRAME_DROP_EN: drop frames that arrive while the target bank is full.
module spectro_frame_pingpong #(
    parameter int DATA_W    = 3,
    parameter int FRAME_LEN = 200,
    localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_index,
    output logic              rd_last,
`ifdef SPECTRO_FRAME_DROP_EN
    output logic [7:0]        drop_count,
`endif
    output logic [1:0]        frames_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] r_mem [2][FRAME_LEN];

    logic              r_wb;
    logic              r_rb;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_rcnt;
    logic [1:0]        r_full;
    logic              r_frame_done;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_rd_index;
    logic              r_rd_last;
    logic [1:0]        r_frames_ready;

    logic              w_wr_fire;
    logic              w_wr_last;
    logic              w_store;
    logic              w_wr_done;
    logic              w_rd_load;
    logic              w_rd_release;
    logic [1:0]        w_full_nxt;

`ifdef SPECTRO_FRAME_DROP_EN
    logic              r_dropping;
    logic [7:0]        r_drop_count;
    logic              w_drop;

    // The drop decision is taken on the first bin and held for the whole frame.
    assign w_drop     = (r_wcnt == '0) ? r_full[r_wb] : r_dropping;
    assign wr_ready   = 1'b1;
    assign w_store    = w_wr_fire & ~w_drop;
    assign drop_count = r_drop_count;
`else
    assign wr_ready   = ~r_full[r_wb];
    assign w_store    = w_wr_fire;
`endif

    assign w_wr_fire    = wr_valid & wr_ready;
    assign w_wr_last    = (r_wcnt == LAST_IDX);
    assign w_wr_done    = w_store & w_wr_last;
    assign w_rd_load    = r_full[r_rb] & (~r_rd_valid | rd_ready);
    assign w_rd_release = w_rd_load & (r_rcnt == LAST_IDX);

    // Completion and release never hit the same bank, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_rd_release) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wb][r_wcnt] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb           <= 1'b0;
            r_rb           <= 1'b0;
            r_wcnt         <= '0;
            r_rcnt         <= '0;
            r_full         <= 2'b00;
            r_frame_done   <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
            r_rd_index     <= '0;
            r_rd_last      <= 1'b0;
            r_frames_ready <= 2'd0;
`ifdef SPECTRO_FRAME_DROP_EN
            r_dropping     <= 1'b0;
            r_drop_count   <= 8'd0;
`endif
        end else begin
            r_full         <= w_full_nxt;
            r_frames_ready <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
            r_frame_done   <= w_wr_done;

            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_wcnt <= '0;
                    if (w_store) begin
                        r_wb <= ~r_wb;
                    end
                end else begin
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                end
            end
`ifdef SPECTRO_FRAME_DROP_EN
            if (w_wr_fire) begin
                r_dropping <= w_drop;
                if (w_wr_last && w_drop && (r_drop_count != 8'hFF)) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
`endif

            if (w_rd_load) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= r_mem[r_rb][r_rcnt];
                r_rd_index <= r_rcnt;
                r_rd_last  <= (r_rcnt == LAST_IDX);
                if (w_rd_release) begin
                    r_rcnt <= '0;
                    r_rb   <= ~r_rb;
                end else begin
                    r_rcnt <= r_rcnt + ADDR_W'(1);
                end
            end else if (rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign frame_done   = r_frame_done;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_index     = r_rd_index;
    assign rd_last      = r_rd_last;
    assign frames_ready = r_frames_ready;

endmodule

// File: tb/tb_spectro_frame_pingpong.sv
// tb/tb_spectro_frame_pingpong.sv - directed bench for spectro_frame_pingpong (FRAME_LEN=4)
module tb_spectro_frame_pingpong;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_index;
    logic          rd_last;
    logic [1:0]    frames_ready;
`ifdef SPECTRO_FRAME_DROP_EN
    logic [7:0]    drop_count;
`endif

    always #5 clk = ~clk;

    spectro_frame_pingpong #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_index     (rd_index),
        .rd_last      (rd_last),
`ifdef SPECTRO_FRAME_DROP_EN
        .drop_count   (drop_count),
`endif
        .frames_ready (frames_ready)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            fd_count = 0;
    int            cyc_n    = 0;
    int            wr_rise  = -1;
    int            last_seen = -1;
    int            c0;
    bit            hold_mode = 1'b0;
    logic [10:0]   rq[$];
    logic [31:0]   eq[$];
    logic [DW-1:0] wq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int idx, input int d);
        return {21'b0, (idx == FL - 1), 2'(idx), 8'(d)};
    endfunction

    task automatic tick();
        logic [11:0] snap;
        bit          hold;
        if (rd_valid && rd_ready) rq.push_back({rd_last, rd_index, rd_data});
        hold = rd_valid && !rd_ready;
        snap = {rd_valid, rd_last, rd_index, rd_data};
        @(posedge clk);
        #1;
        cyc_n++;
        if (frame_done) fd_count++;
        if (wr_ready && wr_rise < 0) wr_rise = cyc_n;
        if (rd_valid && rd_last && last_seen < 0) last_seen = cyc_n;
        if (hold_mode && hold) check("hold", {20'b0, rd_valid, rd_last, rd_index, rd_data}, {20'b0, snap});
    endtask

    task automatic stream(input int cycles, input bit toggle);
        bit acc;
        for (int c = 0; c < cycles; c++) begin
            if (toggle) rd_ready = c[0];
            wr_valid = (wq.size() != 0);
            if (wr_valid) wr_data = wq[0];
            acc = wr_valid && wr_ready;
            tick();
            if (acc) void'(wq.pop_front());
        end
        wr_valid = 1'b0;
        check("wr_drained", wq.size(), 0);
    endtask

    task automatic push_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) begin
            wq.push_back(base + DW'(i));
            eq.push_back(ent(i, int'(base) + i));
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_count"}, rq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            check(tag, (i < rq.size()) ? 32'(rq[i]) : 32'hFFFF_FFFF, eq[i]);
        end
        rq.delete();
        eq.delete();
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_frames_ready", frames_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_out", {rd_last, rd_index, rd_data}, 0);

        // single frame, reader always ready
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < FL; i++) begin
            wr_data = DW'(i + 1);
            tick();
            if (i == FL - 2) check("sf_fd_early", frame_done, 0);
        end
        wr_valid = 1'b0;
        check("sf_frame_done", frame_done, 1);
        check("sf_frames_ready", frames_ready, 1);
        check("sf_not_yet_valid", rd_valid, 0);
        tick();
        check("sf_valid", rd_valid, 1);
        check("sf_bin", {rd_last, rd_index, rd_data}, ent(0, 1));
        for (int k = 1; k < FL; k++) begin
            tick();
            check("sf_bin", {rd_last, rd_index, rd_data}, ent(k, k + 1));
        end
        check("sf_released", frames_ready, 0);
        tick();
        check("sf_drained", rd_valid, 0);
        rq.delete();

`ifndef SPECTRO_FRAME_DROP_EN
        // writer stall: two frames fill both banks, third waits for a release
        rd_ready = 1'b0;
        push_frame(8'h10);
        push_frame(8'h20);
        stream(10, 1'b0);
        check("stall_frames_ready", frames_ready, 2);
        check("stall_wr_ready", wr_ready, 0);
        check("stall_held_valid", rd_valid, 1);
        push_frame(8'h30);
        rd_ready  = 1'b1;
        wr_rise   = -1;
        last_seen = -1;
        c0        = cyc_n;
        stream(24, 1'b0);
        check("stall_last_fetch", last_seen, c0 + 3);
        check("stall_wr_reopen", wr_rise, c0 + 3);
        check("stall_drained", rd_valid, 0);
        check_reads("stall_order");
`endif

        // output hold under toggling rd_ready
        push_frame(8'h40);
        push_frame(8'h50);
        hold_mode = 1'b1;
        stream(40, 1'b1);
        hold_mode = 1'b0;
        rd_ready  = 1'b1;
        tick();
        check_reads("hold_order");

        // reset with one frame full and a partial frame in progress
        rd_ready = 1'b0;
        for (int i = 0; i < FL + 2; i++) wq.push_back(DW'(8'h60 + i));
        stream(FL + 2, 1'b0);
        check("mr_frames_ready_pre", frames_ready, 1);
        check("mr_valid_pre", rd_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_frames_ready", frames_ready, 0);
        check("mr_rd_valid", rd_valid, 0);
        check("mr_wr_ready", wr_ready, 1);
        check("mr_rd_index", rd_index, 0);
`ifdef SPECTRO_FRAME_DROP_EN
        check("mr_drop_count", drop_count, 0);
`endif
        rq.delete();
        push_frame(8'h07);
        rd_ready = 1'b1;
        stream(12, 1'b0);
        check_reads("post_reset");

`ifdef SPECTRO_FRAME_DROP_EN
        // third frame arrives with both banks full and is discarded
        rd_ready = 1'b0;
        fd_count = 0;
        push_frame(8'h80);
        push_frame(8'h90);
        for (int i = 0; i < FL; i++) wq.push_back(DW'(8'hA0 + i));
        stream(3 * FL, 1'b0);
        check("drop_wr_ready", wr_ready, 1);
        check("drop_frames_ready", frames_ready, 2);
        check("drop_count", drop_count, 1);
        check("drop_frame_done", fd_count, 2);
        rd_ready = 1'b1;
        stream(14, 1'b0);
        check_reads("drop_order");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
